// File: rtl/case_2_pkg.sv
// Shared definitions for the case_2 datapath: sequencer state encoding and
// a width helper for iteration counters.
package case_2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/case_2_sdiv_11s_10ns_8_seq.sv
// Sequential restoring divider: signed dividend / unsigned divisor, one quotient
// bit per clock, C-style truncation toward zero, start/done handshake.
module case_2_sdiv_11s_10ns_8_seq
    import case_2_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 11,
    parameter int din1_WIDTH = 10,
    parameter int dout_WIDTH = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH:0]   rem,
    output logic                  dbz
);

    localparam int RW = din1_WIDTH + 1;
    localparam int CW = clog2(din0_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(din0_WIDTH - 1);

    state_t                 state;
    logic [CW-1:0]          count;
    logic [din0_WIDTH-1:0]  q;       // dividend magnitude shifting out, quotient shifting in
    logic [din1_WIDTH-1:0]  r;
    logic [din1_WIDTH-1:0]  d;
    logic                   neg;

    logic [RW-1:0]          shifted;
    logic [RW:0]            diff;
    logic                   fit;
    logic [din1_WIDTH-1:0]  r_step;
    logic [din0_WIDTH-1:0]  q_step;
    logic [din0_WIDTH-1:0]  q_signed;
    logic [din0_WIDTH-1:0]  din0_mag;
    logic [RW-1:0]          rem_signed;
    logic                   dz;

    always_comb begin
        shifted  = {r, q[din0_WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, d};
        // A kept difference is below the divisor, so its top data bit is always clear.
        fit      = ~diff[RW] & ~diff[RW-1];
        r_step   = fit ? diff[din1_WIDTH-1:0] : shifted[din1_WIDTH-1:0];
        q_step   = {q[din0_WIDTH-2:0], fit};
        dz       = (d == '0);
        din0_mag = din0[din0_WIDTH-1] ? (~din0 + 1'b1) : din0;
        if (dz) begin
            // q still holds |din0|, so re-signing it reproduces the dividend.
            q_signed   = neg ? (~q + 1'b1) : q;
            rem_signed = RW'($signed(q_signed));
        end else begin
            q_signed   = neg ? (~q_step + 1'b1) : q_step;
            rem_signed = neg ? (~{1'b0, r_step} + 1'b1) : {1'b0, r_step};
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
            count <= '0;
            q     <= '0;
            r     <= '0;
            d     <= '0;
            neg   <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b0;
            dout  <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q     <= din0_mag;
                        neg   <= din0[din0_WIDTH-1];
                        d     <= din1;
                        r     <= '0;
                        count <= LAST_CNT;
                        ready <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (!dz) begin
                        q <= q_step;
                        r <= r_step;
                    end
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        dout  <= dz ? '1 : q_signed[dout_WIDTH-1:0];
                        rem   <= rem_signed;
                        dbz   <= dz;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
